// File: rtl/mic_frontend_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mic_frontend_mc: multi-channel mic front end with per-channel DC offset     |
// | calibration, saturating offset removal and boxcar decimation.               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mic_frontend_mc #(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 16,
  parameter int DECIM       = 2,
  parameter int OFFSET_LOG2 = 10
) (
  input  logic                    audio_clk,
  input  logic                    rst_in,
  input  logic                    sample_valid_in,
  input  logic [NUM_CH*WIDTH-1:0] sample_in,
  input  logic                    calib_trigger,
  input  logic                    bypass_dc,
  output logic                    sample_valid_out,
  output logic [NUM_CH*WIDTH-1:0] sample_out,
  output logic [NUM_CH*WIDTH-1:0] offset_out,
  output logic                    calibrating,
  output logic                    offset_ready
);

  localparam int c_dlog = $clog2(DECIM);
  localparam int c_pw   = (c_dlog > 0) ? c_dlog : 1;
  localparam int c_sw   = WIDTH + c_dlog;
  localparam int c_aw   = WIDTH + OFFSET_LOG2;
  localparam int c_cw   = OFFSET_LOG2 + 1;
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'((1 << OFFSET_LOG2) - 1);
  localparam logic [c_pw-1:0] c_ph_last  = c_pw'(DECIM - 1);
  localparam logic signed [WIDTH-1:0] c_smax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] c_smin = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_clear;
  logic            w_accum;
  logic            w_commit;
  logic [c_cw-1:0] r_cnt;
  logic            r_offset_ready;
  logic            r_v1;
  logic            r_v2;
  logic            r_vout;
  logic [c_pw-1:0] r_phase;

  always_ff @(posedge audio_clk) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // A trigger always wins over a coincident sample, in every state.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_accum     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE, S_READY: begin
        if (calib_trigger) begin
          w_clear     = 1'b1;
          w_state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (calib_trigger) begin
          w_clear = 1'b1;
        end else if (sample_valid_in) begin
          w_accum = 1'b1;
          if (r_cnt == c_cnt_last) begin
            w_commit    = 1'b1;
            w_state_nxt = S_READY;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge audio_clk) begin
    if (!rst_in) begin
      r_cnt          <= '0;
      r_offset_ready <= 1'b0;
      r_v1           <= 1'b0;
      r_v2           <= 1'b0;
      r_vout         <= 1'b0;
      r_phase        <= '0;
    end else begin
      if (w_clear)      r_cnt <= '0;
      else if (w_accum) r_cnt <= r_cnt + c_cw'(1);
      if (w_commit) r_offset_ready <= 1'b1;
      r_v1   <= sample_valid_in;
      r_v2   <= r_v1 && (r_phase == c_ph_last);
      r_vout <= r_v2;
      if (r_v1) r_phase <= (r_phase == c_ph_last) ? '0 : r_phase + c_pw'(1);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic signed [WIDTH-1:0] w_s;
    logic signed [c_aw-1:0]  w_acc_nxt;
    logic signed [WIDTH:0]   w_diff;
    logic signed [WIDTH-1:0] w_corr;
    logic signed [c_sw-1:0]  w_c_ext;
    logic signed [c_aw-1:0]  r_acc;
    logic signed [WIDTH-1:0] r_offset;
    logic signed [WIDTH-1:0] r_c;
    logic signed [c_sw-1:0]  r_sum;
    logic signed [WIDTH-1:0] r_out;

    assign w_s       = sample_in[k*WIDTH +: WIDTH];
    assign w_acc_nxt = r_acc + c_aw'(w_s);
    assign w_diff    = (WIDTH+1)'(w_s) - (WIDTH+1)'(r_offset);
    assign w_c_ext   = c_sw'(r_c);

    // Top two bits of the widened difference disagree only on overflow.
    always_comb begin
      w_corr = w_diff[WIDTH-1:0];
      if (w_diff[WIDTH] != w_diff[WIDTH-1]) w_corr = w_diff[WIDTH] ? c_smin : c_smax;
    end

    always_ff @(posedge audio_clk) begin
      if (!rst_in) begin
        r_acc    <= '0;
        r_offset <= '0;
        r_c      <= '0;
        r_sum    <= '0;
        r_out    <= '0;
      end else begin
        if (w_clear)      r_acc <= '0;
        else if (w_accum) r_acc <= w_acc_nxt;
        // Bit-slicing the sum above the fraction bits is a floor divide.
        if (w_commit)        r_offset <= w_acc_nxt[OFFSET_LOG2 +: WIDTH];
        if (sample_valid_in) r_c <= bypass_dc ? w_s : w_corr;
        if (r_v1)            r_sum <= (r_phase == '0) ? w_c_ext : r_sum + w_c_ext;
        if (r_v2)            r_out <= r_sum[c_dlog +: WIDTH];
      end
    end

    assign sample_out[k*WIDTH +: WIDTH] = r_out;
    assign offset_out[k*WIDTH +: WIDTH] = r_offset;
  end

  assign sample_valid_out = r_vout;
  assign calibrating      = (r_state == S_ACCUM);
  assign offset_ready     = r_offset_ready;

endmodule
`default_nettype wire

// File: tb/tb_mic_frontend_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mic_frontend_mc: drives a DECIM=2 and a DECIM=4 instance with the same   |
// | stimulus and compares both against an arithmetic reference model.          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mic_frontend_mc;

  localparam int NCH  = 2;
  localparam int W    = 16;
  localparam int OL   = 4;
  localparam int NCAL = 1 << OL;
  localparam int DEC [2] = '{2, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, vin, trig, byp;
  logic [NCH*W-1:0]   sin;
  logic [1:0]         vout, cal, rdy;
  logic [NCH*W-1:0]   sout [2];
  logic [NCH*W-1:0]   oout [2];

  mic_frontend_mc #(.NUM_CH(NCH), .WIDTH(W), .DECIM(2), .OFFSET_LOG2(OL)) u_dut_d2 (
    .audio_clk(clk), .rst_in(rst_n), .sample_valid_in(vin), .sample_in(sin),
    .calib_trigger(trig), .bypass_dc(byp), .sample_valid_out(vout[0]),
    .sample_out(sout[0]), .offset_out(oout[0]), .calibrating(cal[0]), .offset_ready(rdy[0]));

  mic_frontend_mc #(.NUM_CH(NCH), .WIDTH(W), .DECIM(4), .OFFSET_LOG2(OL)) u_dut_d4 (
    .audio_clk(clk), .rst_in(rst_n), .sample_valid_in(vin), .sample_in(sin),
    .calib_trigger(trig), .bypass_dc(byp), .sample_valid_out(vout[1]),
    .sample_out(sout[1]), .offset_out(oout[1]), .calibrating(cal[1]), .offset_ready(rdy[1]));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, per instance.
  longint m_off [2][NCH];
  bit     m_rdy [2];
  bit     m_act [2];
  int     m_cal_n [2];
  longint m_cal_sum [2][NCH];
  int     m_grp_n [2];
  longint m_grp_sum [2][NCH];
  bit     m_p0v [2], m_p1v [2], m_vout [2];
  longint m_p0 [2][NCH], m_p1 [2][NCH], m_out [2][NCH];

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic longint sat(input longint x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int chv(input logic [NCH*W-1:0] v, input int k);
    logic signed [W-1:0] t;
    t = v[k*W +: W];
    return int'(t);
  endfunction

  function automatic int rnd16();
    logic signed [W-1:0] t;
    t = W'($urandom());
    return int'(t);
  endfunction

  task automatic model_edge();
    longint s [NCH];
    longint c;
    for (int k = 0; k < NCH; k++) s[k] = chv(sin, k);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_rdy[d] = 0; m_act[d] = 0; m_cal_n[d] = 0; m_grp_n[d] = 0;
        m_p0v[d] = 0; m_p1v[d] = 0; m_vout[d] = 0;
        for (int k = 0; k < NCH; k++) begin
          m_off[d][k] = 0; m_cal_sum[d][k] = 0; m_grp_sum[d][k] = 0;
          m_out[d][k] = 0; m_p0[d][k] = 0; m_p1[d][k] = 0;
        end
      end else begin
        // A group finishing at edge T becomes visible at edge T+2.
        m_vout[d] = m_p1v[d];
        for (int k = 0; k < NCH; k++) begin
          if (m_p1v[d]) m_out[d][k] = m_p1[d][k];
          m_p1[d][k] = m_p0[d][k];
        end
        m_p1v[d] = m_p0v[d];
        m_p0v[d] = 0;
        if (vin) begin
          for (int k = 0; k < NCH; k++) begin
            c = byp ? s[k] : sat(s[k] - m_off[d][k]);
            m_grp_sum[d][k] += c;
          end
          m_grp_n[d]++;
          if (m_grp_n[d] == DEC[d]) begin
            for (int k = 0; k < NCH; k++) begin
              m_p0[d][k] = floor_div(m_grp_sum[d][k], DEC[d]);
              m_grp_sum[d][k] = 0;
            end
            m_p0v[d] = 1;
            m_grp_n[d] = 0;
          end
        end
        if (trig) begin
          m_act[d] = 1; m_cal_n[d] = 0;
          for (int k = 0; k < NCH; k++) m_cal_sum[d][k] = 0;
        end else if (m_act[d] && vin) begin
          for (int k = 0; k < NCH; k++) m_cal_sum[d][k] += s[k];
          m_cal_n[d]++;
          if (m_cal_n[d] == NCAL) begin
            for (int k = 0; k < NCH; k++) m_off[d][k] = floor_div(m_cal_sum[d][k], NCAL);
            m_rdy[d] = 1; m_act[d] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("d%0d_vout", d), vout[d], m_vout[d]);
      check_val($sformatf("d%0d_cal", d), cal[d], m_act[d]);
      check_val($sformatf("d%0d_rdy", d), rdy[d], m_rdy[d]);
      for (int k = 0; k < NCH; k++) begin
        check_val($sformatf("d%0d_out%0d", d, k), chv(sout[d], k), m_out[d][k]);
        check_val($sformatf("d%0d_off%0d", d, k), chv(oout[d], k), m_off[d][k]);
      end
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit t, input bit b,
                       input int a0, input int a1);
    rst_n = r; vin = v; trig = t; byp = b;
    sin = {W'(a1), W'(a0)};
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic valids(input int n, input bit b, input int a0, input int a1);
    for (int i = 0; i < n; i++) begin
      drive(1, 1, 0, b, a0, a1);
      step();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    // Reset held with random activity on the inputs.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rnd16(), rnd16());
      step();
    end
    check_val("rst_cal", cal[1], 0);
    check_val("rst_rdy", rdy[0], 0);
    check_val("rst_out", chv(sout[1], 0), 0);

    // Decimation, no calibration.
    valids(1, 0, 100, -300);
    valids(1, 0, 200, -101);
    idle(1);
    check_val("dec_early", vout[0], 0);
    idle(1);
    check_val("dec_vout", vout[0], 1);
    check_val("dec_ch0", chv(sout[0], 0), 150);
    check_val("dec_ch1", chv(sout[0], 1), -201);
    valids(2, 0, 4, 8);
    idle(3);

    // Calibration to {-50, 1000}.
    drive(1, 0, 1, 0, 0, 0); step();
    for (int i = 0; i < NCAL; i++) begin
      drive(1, 1, 0, 0, 1000, -50);
      #0 check_val("cal_high", cal[1], 1);
      step();
    end
    check_val("cal_off0", chv(oout[1], 0), 1000);
    check_val("cal_off1", chv(oout[1], 1), -50);
    check_val("cal_rdy", rdy[1], 1);
    check_val("cal_done", cal[1], 0);
    valids(4, 0, 1000, -50);
    idle(2);
    check_val("corr_ch0", chv(sout[1], 0), 0);
    check_val("corr_ch1", chv(sout[1], 1), 0);
    valids(4, 1, 1000, -50);
    idle(2);
    check_val("byp_ch0", chv(sout[1], 0), 1000);
    check_val("byp_ch1", chv(sout[1], 1), -50);

    // Saturation in both directions.
    drive(1, 0, 1, 0, 0, 0); step();
    valids(NCAL, 0, -1000, 1000);
    valids(4, 0, 32700, -32768);
    idle(2);
    check_val("sat_hi", chv(sout[1], 0), 32767);
    check_val("sat_lo", chv(sout[1], 1), -32768);

    // Retrigger coincident with the 8th sample.
    drive(1, 0, 1, 0, 0, 0); step();
    valids(7, 0, 5000, 5000);
    drive(1, 1, 1, 0, 5000, 5000); step();
    check_val("retrig_cal", cal[1], 1);
    valids(NCAL - 1, 0, 123, -7);
    check_val("retrig_nocommit", chv(oout[1], 0), -1000);
    valids(1, 0, 123, -7);
    check_val("retrig_off0", chv(oout[1], 0), 123);
    check_val("retrig_off1", chv(oout[1], 1), -7);
    idle(2);

    // Reset in the middle of a calibration and a decimation group.
    drive(1, 0, 1, 0, 0, 0); step();
    valids(2, 0, 9999, 9999);
    drive(0, 0, 0, 0, 0, 0); step();
    check_val("mrst_off", chv(oout[1], 0), 0);
    check_val("mrst_cal", cal[1], 0);
    valids(1, 0, 10, -1);
    valids(1, 0, 21, -2);
    valids(1, 0, -5, -3);
    valids(1, 0, 7, -4);
    idle(1);
    check_val("mrst_early", vout[1], 0);
    idle(1);
    check_val("mrst_vout", vout[1], 1);
    check_val("mrst_ch0", chv(sout[1], 0), 8);
    check_val("mrst_ch1", chv(sout[1], 1), -3);

    // Randomized traffic with occasional triggers, bypass and resets.
    for (int i = 0; i < 4000; i++) begin
      bit r, v, t, b;
      int a0, a1;
      r = ($urandom_range(0, 599) != 0);
      v = (i % 1000 < 300) ? 1'b1 : 1'($urandom_range(0, 1));
      t = ($urandom_range(0, 149) == 0);
      b = ((i / 250) % 4 == 3);
      if ((i / 500) % 2 == 0) begin
        a0 = rnd16(); a1 = rnd16();
      end else begin
        a0 = 2000 + int'($urandom_range(0, 40)) - 20;
        a1 = -3000 + int'($urandom_range(0, 40)) - 20;
      end
      drive(r, v, t, b, a0, a1);
      step();
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mic_frontend_mc.md
Name: mic_frontend_mc

Overview:
Parametrised multi-channel microphone front end. It takes time-aligned per-channel PCM samples from the i2s receivers, measures a per-channel DC offset on request, removes that offset with saturation, and boxcar-decimates by DECIM. It sits between the i2s mics and the FIR/all-pass/convolution chain and replaces the single-channel offset, correction and decimation logic.

Parameters:
NUM_CH, 2, number of mic channels (1..8)
WIDTH, 16, signed sample width, in and out
DECIM, 2, decimation factor; power of 2, 1..16 (1 = pass-through, no averaging)
OFFSET_LOG2, 10, calibration averages 2^OFFSET_LOG2 input samples per channel

Ports:
audio_clk  in  1  system audio clock (98.3 MHz)
rst_in  in  1  synchronous, active-low reset (0 = reset)
sample_valid_in  in  1  one-cycle strobe: all channels present a new sample
sample_in  in  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH], signed
calib_trigger  in  1  one-cycle strobe: start or restart offset calibration
bypass_dc  in  1  1 = skip offset subtraction (offsets still measured and held)
sample_valid_out  out  1  one-cycle strobe: new decimated sample on all channels
sample_out  out  NUM_CH*WIDTH  decimated, offset-corrected samples, same packing as sample_in
offset_out  out  NUM_CH*WIDTH  committed per-channel offsets, same packing
calibrating  out  1  high while in state ACCUM
offset_ready  out  1  high once at least one calibration has committed

Behaviour:
- Reset (rst_in=0 at a clock edge): all outputs 0; offset registers 0; accumulators 0; sample counter 0; decimation phase 0; pipeline valids cleared; FSM in IDLE.
- Calibration FSM, states IDLE, ACCUM, READY:
  - IDLE or READY, calib_trigger=1: clear accumulators and counter, go to ACCUM.
  - ACCUM, each sample_valid_in: acc[k] += sign-extended sample_in[k]. Each accumulator is WIDTH+OFFSET_LOG2 bits and cannot overflow. The counter increments.
  - ACCUM, on the 2^OFFSET_LOG2-th valid: offset[k] = acc[k] >>> OFFSET_LOG2 (arithmetic shift, floor). Go to READY. offset_out updates and offset_ready rises on the following edge.
  - calib_trigger during ACCUM restarts it: accumulators and counter are cleared.
  - calib_trigger and sample_valid_in in the same cycle: the trigger wins; that sample is not accumulated but still flows through the datapath.
  - During ACCUM the previously committed offsets (0 if none) remain in use; offset_ready keeps its prior value.
  - The sample that completes calibration is corrected with the old offset. The new offset applies from the next valid.
- Datapath per channel:
  - Stage 1, registered on sample_valid_in: c = sample − offset, or c = sample when bypass_dc=1.
  - The subtraction is computed in WIDTH+1 bits and saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Decimation:
  - The phase counter counts stage-1 valids from 0 to DECIM−1.
  - sum[k] accumulates c in WIDTH+log2(DECIM) bits. At phase 0, sum is loaded with c instead of added to.
  - When phase reaches DECIM−1: sample_out[k] = sum_final >>> log2(DECIM) (floor), sample_valid_out pulses, phase wraps to 0.
- Latency: a sample_valid_in at edge T that completes a decimation group gives sample_valid_out high for exactly one cycle after edge T+2.
- sample_out holds its value between valids.
- Throughput: back-to-back sample_valid_in (every cycle) is supported with no loss.
- Reset mid-operation: aborts calibration, discards any partial decimation group, and zeros the committed offsets.

Test Plan:
- Reset check: hold rst_in=0 for 3 cycles while driving random inputs and strobes -> all outputs 0; calibrating=0; offset_ready=0.
- Decimation with NUM_CH=2, DECIM=2, no calibration: ch0 100 then 200, ch1 −300 then −101 -> one sample_valid_out 2 cycles after the second valid; ch0=150, ch1=−201.
- Calibration with OFFSET_LOG2=4: pulse calib_trigger, then 16 valids with ch0=1000 and ch1=−50 constant -> calibrating high through the 16th valid; offset_out = {−50, 1000}; offset_ready=1 one cycle later; subsequent outputs 0 on both channels; with bypass_dc=1 outputs are 1000 and −50.
- Saturation: commit ch0 offset −1000 (constant −1000 input), then feed 32700 -> sample_out ch0 = 32767. Feed −32768 with offset +1000 -> −32768.
- Retrigger: calib_trigger, 7 valids, then calib_trigger coincident with the 8th valid -> no commit until 16 further valids; offsets computed only from those 16 samples; calibrating stays continuously high.
- Reset mid-operation: DECIM=4, after 2 valids and during ACCUM, pull rst_in low for 1 cycle -> IDLE, offsets 0. The next sample_valid_out comes only after 4 fresh valids and averages only those.
